ws2812b_chain_sequencer: RTL and testbench

WS2812B_CHAIN_SEQUENCER -- requirements
Module: ws2812b_chain_sequencer

---
 rtl/ws2812b_chain_sequencer.sv | 147 ++++++++++++++
 tb/tb_ws2812b_chain_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_chain_sequencer.sv
// WS2812B chain sequencer: fetches {G,R,B} per LED through o_led_index and
// serialises the whole chain MSB first, then holds the line low to latch.
module ws2812b_chain_sequencer #(
  parameter int NUM_LEDS  = 8,
  parameter int T_BIT     = 63,
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int T_RESET   = 15000,
  localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       i_led_green_intensity,
  input  logic [7:0]       i_led_red_intensity,
  input  logic [7:0]       i_led_blue_intensity,
  output logic [IDX_W-1:0] o_led_index,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_data
);

  localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RESET - 1);
  localparam logic [IDX_W-1:0] LED_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [4:0]       BIT_PRE  = 5'd22;
  localparam logic [4:0]       BIT_END  = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [IDX_W-1:0] led_q, led_d;
  logic             last_q, last_d;
  logic [23:0]      shreg_q, shreg_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [23:0]      colour;

  function automatic logic [CNT_W-1:0] high_time(input logic b);
    return b ? CNT_W'(T1H) : CNT_W'(T0H);
  endfunction

  assign colour = {i_led_green_intensity, i_led_red_intensity, i_led_blue_intensity};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    led_d   = led_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        led_d  = '0;
        last_d = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = colour;
        state_d = SEND;
      end
      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_END) begin
            if (last_q) begin
              state_d = LATCH;
            end else begin
              // next LED's colour was addressed a whole bit ago; load it seamlessly
              shreg_d = colour;
              bit_d   = '0;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
            if (bit_q == BIT_PRE) begin
              if (led_q == LED_LAST) last_d = 1'b1;
              else                   led_d  = led_q + IDX_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          led_d   = '0;
          last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are derived from next-state values so they line up with the state
    data_d = (state_d == SEND) && (cnt_d < high_time(shreg_d[23]));
    busy_d = (state_d != IDLE);
    done_d = (state_d == LATCH) && (cnt_d == RST_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      last_q  <= 1'b0;
      shreg_q <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_led_index = led_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_data      = data_q;

endmodule

// File: tb/tb_ws2812b_chain_sequencer.sv
// Bench for ws2812b_chain_sequencer: frame-level timing model plus directed frames
// on a 2-LED chain and a 1-LED chain.
module tb_ws2812b_chain_sequencer;

  localparam int TB = 10;
  localparam int T0 = 3;
  localparam int T1 = 7;
  localparam int TR = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  g2, r2, b2, g1, r1, b1;
  logic [0:0]  idx2, idx1;
  logic        busy2, done2, data2, busy1, done1, data1;
  logic [23:0] colA [2];
  logic [23:0] colB = 24'h0;
  logic [23:0] noise = 24'h0;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  bit act2 = 1'b0;
  bit act1 = 1'b0;
  int k2 = 0;
  int k1 = 0;
  int run2 = 0;
  int run1 = 0;
  int runs2[$];
  int runs1[$];

  ws2812b_chain_sequencer #(.NUM_LEDS(2), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .i_led_green_intensity(g2), .i_led_red_intensity(r2), .i_led_blue_intensity(b2),
    .o_led_index(idx2), .o_busy(busy2), .o_done(done2), .o_data(data2)
  );

  ws2812b_chain_sequencer #(.NUM_LEDS(1), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .i_led_green_intensity(g1), .i_led_red_intensity(r1), .i_led_blue_intensity(b1),
    .o_led_index(idx1), .o_busy(busy1), .o_done(done1), .o_data(data1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int frame_len(input int n);
    return 1 + 24 * n * TB + TR;
  endfunction

  // Cycle k of a frame counts from the LOAD cycle (k = 0).
  function automatic bit is_cap(input int n, input bit act, input int k);
    int s;
    if (!act) return 1'b0;
    if (k == 0) return 1'b1;
    s = k - 1;
    return (k <= 24 * n * TB) && (s % (24 * TB) == 24 * TB - 1) && (s / (24 * TB) < n - 1);
  endfunction

  function automatic void model_out(input int n, input bit act, input int k,
                                    input logic [23:0] c0, input logic [23:0] c1,
                                    output bit d, output bit bsy, output bit dn, output int idx);
    int send, s, led, bt, ph;
    logic [23:0] c;
    send = 24 * n * TB;
    d = 1'b0; bsy = act; dn = 1'b0; idx = 0;
    if (act && k >= 1 && k <= send) begin
      s   = k - 1;
      led = s / (24 * TB);
      bt  = (s / TB) % 24;
      ph  = s % TB;
      c   = (led == 0) ? c0 : c1;
      d   = (ph < (c[5'(23 - bt)] ? T1 : T0));
      idx = (bt == 23 && led < n - 1) ? led + 1 : led;
    end else if (act && k > send) begin
      idx = n - 1;
      dn  = (k == send + TR);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act2 <= 1'b0; k2 <= 0; act1 <= 1'b0; k1 <= 0;
    end else begin
      if (act2) begin
        if (k2 == frame_len(2) - 1) act2 <= 1'b0;
        else k2 <= k2 + 1;
      end else if (start2) begin
        act2 <= 1'b1; k2 <= 0;
      end
      if (act1) begin
        if (k1 == frame_len(1) - 1) act1 <= 1'b0;
        else k1 <= k1 + 1;
      end else if (start1) begin
        act1 <= 1'b1; k1 <= 0;
      end
    end
  end

  // Real colours only on the capture cycles; noise everywhere else.
  always @(negedge clk) noise <= 24'($urandom);

  always_comb begin
    {g2, r2, b2} = noise;
    if (is_cap(2, act2, k2)) {g2, r2, b2} = colA[idx2];
    {g1, r1, b1} = ~noise;
    if (is_cap(1, act1, k1)) {g1, r1, b1} = colB;
  end

  always @(negedge clk) begin : cmp
    bit ed, eb, en;
    int ei;
    model_out(2, act2, k2, colA[0], colA[1], ed, eb, en, ei);
    check("data2", 32'(data2), 32'(ed));
    check("busy2", 32'(busy2), 32'(eb));
    check("done2", 32'(done2), 32'(en));
    check("idx2",  32'(idx2),  32'(ei));
    model_out(1, act1, k1, colB, colB, ed, eb, en, ei);
    check("data1", 32'(data1), 32'(ed));
    check("busy1", 32'(busy1), 32'(eb));
    check("done1", 32'(done1), 32'(en));
    check("idx1",  32'(idx1),  32'(ei));
    if (data2 === 1'b1) run2++;
    else if (run2 > 0) begin runs2.push_back(run2); run2 = 0; end
    if (data1 === 1'b1) run1++;
    else if (run1 > 0) begin runs1.push_back(run1); run1 = 0; end
  end

  task automatic run_frame(input bit sel, output int load_c, output int done_c,
                           output int idx22, output int idx23);
    int lim;
    load_c = -1; done_c = -1; idx22 = -1; idx23 = -1;
    check("busy_before_start", 32'(sel ? busy1 : busy2), 32'd0);
    if (sel) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    if (sel) start1 = 1'b0; else start2 = 1'b0;
    check("busy_after_start", 32'(sel ? busy1 : busy2), 32'd1);
    load_c = cyc;
    lim = 0;
    while ((sel ? done1 : done2) !== 1'b1 && lim < 2000) begin
      @(negedge clk);
      lim++;
      if (cyc - load_c == 230) idx22 = int'(sel ? idx1 : idx2);
      if (cyc - load_c == 231) idx23 = int'(sel ? idx1 : idx2);
    end
    if (lim >= 2000) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      done_c = cyc;
      check("idx_in_latch", 32'(sel ? idx1 : idx2), sel ? 32'd0 : 32'd1);
      @(negedge clk);
      check("busy_after_done", 32'(sel ? busy1 : busy2), 32'd0);
      check("idx_after_done", 32'(sel ? idx1 : idx2), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int load_c, done_c, i22, i23, nd, gapcnt, lim, sevens, threes;
    int gaps[$];
    colA[0] = 24'h800001;
    colA[1] = 24'hFFFFFF;
    colB    = 24'h000000;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_data", 32'(data2), 32'd0);
    check("rst_done", 32'(done2), 32'd0);
    check("rst_idx",  32'(idx2),  32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy2), 32'd0);

    // Frame 1: LED0 = 80/00/01, LED1 = FF/FF/FF
    runs2.delete();
    run_frame(1'b0, load_c, done_c, i22, i23);
    check("t1_runs", 32'(runs2.size()), 32'd48);
    if (runs2.size() >= 48) begin
      check("t1_bit0_high",  32'(runs2[0]),  32'd7);
      check("t1_bit1_high",  32'(runs2[1]),  32'd3);
      check("t1_bit22_high", 32'(runs2[22]), 32'd3);
      check("t1_bit23_high", 32'(runs2[23]), 32'd7);
      sevens = 0;
      for (int i = 24; i < 48; i++) if (runs2[i] == 7) sevens++;
      check("t1_led1_ones", 32'(sevens), 32'd24);
    end
    check("t1_done_offset", 32'(done_c - load_c), 32'd500);
    check("t1_idx_bit22", 32'(i22), 32'd0);
    check("t1_idx_bit23", 32'(i23), 32'd1);

    // start held high across three frames
    colA[0] = 24'($urandom);
    colA[1] = 24'($urandom);
    start2 = 1'b1;
    nd = 0; gapcnt = 0; lim = 0;
    while (nd < 3 && lim < 3000) begin
      @(negedge clk);
      lim++;
      if (done2 === 1'b1) begin
        nd++;
        if (nd == 3) start2 = 1'b0;
        gapcnt = 0;
      end else if (busy2 === 1'b0) begin
        gapcnt++;
      end else if (gapcnt > 0) begin
        gaps.push_back(gapcnt);
        gapcnt = 0;
      end
    end
    check("t2_frames", 32'(nd), 32'd3);
    check("t2_gap_count", 32'(gaps.size()), 32'd2);
    if (gaps.size() == 2) begin
      check("t2_gap0", 32'(gaps[0]), 32'd1);
      check("t2_gap1", 32'(gaps[1]), 32'd1);
    end
    repeat (5) @(negedge clk);
    check("t2_no_queued_start", 32'(busy2), 32'd0);

    // async reset mid-bit (bit 5 of LED1)
    colA[0] = 24'h800001;
    colA[1] = 24'hFFFFFF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    load_c = cyc;
    repeat (291) @(negedge clk);
    check("t3_data_before_rst", 32'(data2), 32'd1);
    check("t3_idx_before_rst",  32'(idx2),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t3_rst_data", 32'(data2), 32'd0);
    check("t3_rst_busy", 32'(busy2), 32'd0);
    check("t3_rst_done", 32'(done2), 32'd0);
    check("t3_rst_idx",  32'(idx2),  32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_idle_after_rst", 32'(busy2), 32'd0);
    runs2.delete();
    run_frame(1'b0, load_c, done_c, i22, i23);
    check("t3_runs", 32'(runs2.size()), 32'd48);
    if (runs2.size() >= 2) begin
      check("t3_bit0_high", 32'(runs2[0]), 32'd7);
      check("t3_bit1_high", 32'(runs2[1]), 32'd3);
    end
    check("t3_done_offset", 32'(done_c - load_c), 32'd500);

    // single-LED chain, all-zero colour
    runs1.delete();
    run_frame(1'b1, load_c, done_c, i22, i23);
    check("t4_runs", 32'(runs1.size()), 32'd24);
    threes = 0;
    foreach (runs1[i]) if (runs1[i] == 3) threes++;
    check("t4_zero_bits", 32'(threes), 32'd24);
    check("t4_done_offset", 32'(done_c - load_c), 32'd260);
    check("t4_idx_bit22", 32'(i22), 32'd0);
    check("t4_idx_bit23", 32'(i23), 32'd0);

    // mixed colour pattern on the 2-LED chain
    colA[0] = 24'hA53C96;
    colA[1] = 24'h0F00F1;
    runs2.delete();
    run_frame(1'b0, load_c, done_c, i22, i23);
    check("t5_runs", 32'(runs2.size()), 32'd48);
    if (runs2.size() >= 48) begin
      check("t5_bit0_high",  32'(runs2[0]),  32'd7);
      check("t5_bit1_high",  32'(runs2[1]),  32'd3);
      check("t5_led1_bit4",  32'(runs2[28]), 32'd7);
      check("t5_led1_bit47", 32'(runs2[47]), 32'd7);
    end
    check("t5_done_offset", 32'(done_c - load_c), 32'd500);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
